icache: RTL
===========

Name: icache

Overview:
- Direct-mapped instruction cache; the responder end of the fetch-stage request interface (request + 18-bit address in, instruction-valid pulse + 32-bit word out).
- On a miss, refills one 4-byte line through the byte-wide memory-controller (MC) port with a hold-until-done handshake, then answers the pending fetch.
- Sits between the IF stage and the MC arbiter; read-only.
- No coherence with stores.

Parameters:
- LINES, 128, number of one-word lines; power of two; index width IDX_W = log2(LINES) = 7.
- ADDR_W, 18, byte-address width of the fetch and MC ports.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset, asynchronous, active-high.
- rdy_in  in  1  global ready; 0 freezes every register.
- req_in  in  1  fetch request from IF; level, held until answered or withdrawn.
- addr_in  in  ADDR_W  fetch byte address; bits [1:0] are always 00.
- instE_out  out  1  one-cycle pulse: inst_out is valid for the address requested.
- inst_out  out  32  fetched instruction, little-endian.
- mcReq_out  out  1  byte-read request to the MC; held until mcDone_in.
- mcAddr_out  out  ADDR_W  byte address of the read.
- mcDone_in  in  1  MC read complete this cycle; mcByte_in is valid.
- mcByte_in  in  8  returned byte.

Behaviour:
- Address split:
  - index = addr[IDX_W+1:2].
  - tag = addr[ADDR_W-1:IDX_W+2] (9 bits at default).
- Storage per line: valid bit, tag, 32-bit data.
- Reset (asynchronous):
  - All valid bits = 0; state = IDLE; byte counter = 0.
  - instE_out = 0, inst_out = 0, mcReq_out = 0, mcAddr_out = 0.
  - Tag and data arrays need no reset.
- rdy_in = 0: no state, array or output register changes. A pulse already on instE_out is held until rdy returns.
- All outputs are registered.
- FSM:
  - IDLE:
    - Condition for action: req_in = 1 and instE_out = 0. The guard ignores the still-high request in the cycle the pulse is visible.
    - Hit (valid and tag match): next cycle instE_out = 1 and inst_out = line data, for exactly one cycle. Hit latency is 1 cycle.
    - Miss: latch the line base address, counter = 0, mcReq_out = 1, mcAddr_out = base; go to FETCH.
  - FETCH:
    - Hold mcReq_out and mcAddr_out steady until mcDone_in.
    - On each mcDone_in: store mcByte_in into assembly byte[counter] and increment the counter.
    - If counter was < 3: mcAddr_out = base + counter + 1, with mcReq_out staying 1 (back-to-back allowed).
    - If counter was 3: mcReq_out = 0; go to FILL.
    - mcDone_in while mcReq_out = 0 is ignored.
  - FILL (1 cycle):
    - Write data, tag and valid = 1 into the line.
    - If req_in = 1 and addr_in equals the latched address: assert instE_out with the assembled word next cycle.
    - Otherwise (request withdrawn on jump/MEM-access, or address changed): no pulse.
    - Go to IDLE.
- Refill never aborts once started; the line is always completed. This avoids a torn MC handshake.
- Miss penalty: 4 MC transactions + 2 cycles.
- instE_out is never high in two consecutive cycles.
- A request arriving during FETCH/FILL is sampled only in IDLE.
- Reset mid-FETCH: mcReq_out drops immediately; the partial line is discarded (valid stays 0).
- Address wrap: the byte-address increment stays within the line, so there is no carry out of bits [1:0]; an 18-bit overflow cannot occur.

Decomposition:
- Shared defines header (extend the existing one):
  - ADDR_W, instruction width, Enable/Disable.
  - icache state encoding (IDLE/FETCH/FILL).
  - Index/tag field macros.
- One sub-module, icache_array: valid/tag/data storage with a combinational read, a single write port and an asynchronous valid clear.
- FSM and handshake logic remain in icache.

Test Plan:
- Cold miss:
  - Stimulus: reset, then req=1, addr=0x00010; MC returns bytes 13,05,00,00 with 1-cycle done latency.
  - Expected MC addresses: 0x10, 0x11, 0x12, 0x13.
  - Expected response: instE pulse once with inst=0x00000513.
- Hit: re-request 0x00010 after the previous pulse -> instE one cycle later with 0x00000513; mcReq_out stays 0.
- Conflict eviction:
  - Stimulus: fetch 0x00210 (same index, tag 1), data 0xDEADBEEF; then fetch 0x00010.
  - Expected: both miss and refill; the final response is from MC, not stale data.
- Withdrawal:
  - Stimulus: miss on 0x00020; drop req after the second byte; re-request 0x00020 once idle.
  - Expected: the refill completes with no instE pulse; the re-request hits with 1-cycle latency.
- rdy stall:
  - Stimulus: hold rdy_in=0 for 5 cycles mid-FETCH with mcDone_in pulsing.
  - Expected: counter/addr unchanged and no byte captured; the refill resumes correctly after rdy returns.
- Async reset:
  - Stimulus: assert rst between clock edges mid-FETCH.
  - Expected: mcReq_out=0 and instE_out=0 without waiting for a clock edge; a subsequent fetch of the same address misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// Field helpers split a fetch byte address into index and tag.
package icache_pkg;

    localparam int ADDR_W = 18;
    localparam int INST_W = 32;
    localparam int LINES  = 128;
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - IDX_W - 2;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FILL  = 2'd2
    } ic_state_t;

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
        return a[IDX_W+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:IDX_W+2];
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read, one write port,
// valid bits cleared asynchronously, tag/data left unreset.
module icache_array
    import icache_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [INST_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [INST_W-1:0] wr_data
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [INST_W-1:0] data_q [LINES];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= ENABLE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: 1-cycle hits, misses refill one
// 4-byte line through the byte-wide memory-controller port.
module icache
    import icache_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              req_in,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              instE_out,
    output logic [INST_W-1:0] inst_out,
    output logic              mcReq_out,
    output logic [ADDR_W-1:0] mcAddr_out,
    input  logic              mcDone_in,
    input  logic [7:0]        mcByte_in
);

    ic_state_t         state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [INST_W-1:0] asm_q, asm_d;
    logic              inst_e_d;
    logic [INST_W-1:0] inst_d;
    logic              mc_req_d;
    logic [ADDR_W-1:0] mc_addr_d;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [INST_W-1:0] rd_data;
    logic              wr_en;
    logic              hit;

    icache_array u_array (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .rd_idx  (idx_of(addr_in)),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_idx  (idx_of(base_q)),
        .wr_tag  (tag_of(base_q)),
        .wr_data (asm_q)
    );

    assign hit   = rd_valid && (rd_tag == tag_of(addr_in));
    assign wr_en = rdy_in && (state_q == S_FILL);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            base_q     <= '0;
            asm_q      <= '0;
            instE_out  <= DISABLE;
            inst_out   <= '0;
            mcReq_out  <= DISABLE;
            mcAddr_out <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            asm_q      <= asm_d;
            instE_out  <= inst_e_d;
            inst_out   <= inst_d;
            mcReq_out  <= mc_req_d;
            mcAddr_out <= mc_addr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        asm_d     = asm_q;
        inst_e_d  = DISABLE;
        inst_d    = inst_out;
        mc_req_d  = mcReq_out;
        mc_addr_d = mcAddr_out;
        unique case (state_q)
            S_IDLE: begin
                // a visible pulse means the held request was just served
                if (req_in && !instE_out) begin
                    if (hit) begin
                        inst_e_d = ENABLE;
                        inst_d   = rd_data;
                    end else begin
                        base_d    = addr_in;
                        cnt_d     = '0;
                        mc_req_d  = ENABLE;
                        mc_addr_d = addr_in;
                        state_d   = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (mcReq_out && mcDone_in) begin
                    asm_d[{cnt_q, 3'b000} +: 8] = mcByte_in;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        mc_req_d = DISABLE;
                        state_d  = S_FILL;
                    end else begin
                        mc_addr_d = {base_q[ADDR_W-1:2], cnt_q + 2'd1};
                    end
                end
            end
            S_FILL: begin
                if (req_in && (addr_in == base_q)) begin
                    inst_e_d = ENABLE;
                    inst_d   = asm_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
